singlecycleregfile: RTL and testbench
=====================================

# singlecycleregfile

Architectural register file and ALU status register for the single-cycle RISC-V core. It sits on both sides of the ALU. The two read ports supply ALU operands `i1`/`i2`, and the write port takes the ALU `out` (or load data) at the end of the cycle. A 4-bit flag register captures the ALU zero/negative/carry/overflow flags, and a sticky-overflow bit accumulates overflow events for software inspection.

## Interface

Parameters:

- `XLEN`, 32: data width of each register and each port.
- `BYPASS`, 0: when 1, a same-cycle write is forwarded to the read ports (write-through). Must stay 0 in the single-cycle core, because the ALU feeds `rd_data` combinationally and forwarding would create a loop.

Ports:

- `clk`, input, 1: single clock, rising-edge active.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rs1_addr`, input, 5: read port 1 address.
- `rs2_addr`, input, 5: read port 2 address.
- `rs1_data`, output, XLEN: read port 1 data, drives ALU `i1`.
- `rs2_data`, output, XLEN: read port 2 data, drives the ALU `i2` mux.
- `rd_we`, input, 1: register write enable.
- `rd_addr`, input, 5: write address.
- `rd_data`, input, XLEN: write data.
- `flag_we`, input, 1: capture the ALU flags this cycle.
- `zero_in`, `neg_in`, `carry_in`, `ovf_in`, input, 1 each: ALU flag inputs.
- `flags`, output, 4: registered `{Z,N,C,V}`, with `flags[3]` = Z.
- `sticky_ovf`, output, 1: set by any captured overflow, held until cleared.
- `sticky_clr`, input, 1: synchronous clear of `sticky_ovf`.

## Operation

- **Storage:** 31 writable XLEN-bit registers, x1..x31.
- **x0:** hardwired to zero. Reads of address 0 return 0 regardless of `BYPASS`. Writes to address 0 are discarded with no side effect.
- **Reads:** combinational and independent. Both ports may address the same register.
- **BYPASS=1 forwarding:** if `rd_we` && `rd_addr`!=0 && `rd_addr`==`rsN_addr`, then `rsN_data` = `rd_data`. Otherwise the stored value is returned.
- **Writes:** on the rising `clk` edge with `rd_we`=1 and `rd_addr`!=0, the addressed register becomes `rd_data`. No other register changes.
- **Flag capture:** on the rising edge with `flag_we`=1, `flags` <= `{zero_in,neg_in,carry_in,ovf_in}`. With `flag_we`=0, `flags` holds.
- **Sticky overflow, next state per edge:**
  - set if `flag_we` && `ovf_in`;
  - else clear if `sticky_clr`;
  - else hold.
  - Set beats clear when both occur in the same cycle, so no overflow event is lost.
- `flag_we` and `rd_we` are independent and may be asserted in the same cycle.
- **Reset:** `rst_n`=0 asynchronously forces x1..x31 to 0, `flags` to 4'b0000, and `sticky_ovf` to 0.
  - Reset takes effect immediately, mid-cycle, even with `rd_we` asserted. Read outputs reflect zero without waiting for a clock edge.
  - After `rst_n` rises, the first active edge performs normal writes.
- Out-of-range conditions do not exist: all 5-bit addresses are valid.

## Timing

- **Read latency:** 0 cycles, purely combinational from address to data.
- **Write latency:** 1 edge. A value written at edge N is readable from edge N onward, and visible through the read ports in cycle N+1 when `BYPASS`=0.
- **Flag latency:** 1 edge. `flags` and `sticky_ovf` reflect inputs sampled at edge N during cycle N+1. Branch logic must therefore use ALU flags directly for same-instruction decisions and `flags` only for later instructions.
- **Reset values:**
  - `rs1_data` = 0 and `rs2_data` = 0 for any address;
  - `flags` = 0;
  - `sticky_ovf` = 0.
- No handshake is used: every write request is accepted on the edge at which it is presented.

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle while `rd_we`=1, `rd_addr`=5, `rd_data`=32'h1234_5678 -> `rs1_data`(addr 5) reads 0 immediately. After release and one write edge, it reads 32'h1234_5678.
- **x0:** write 32'hDEAD_BEEF to addr 0, then read addr 0 on both ports -> 0. Write 32'hA5A5_A5A5 to x31 -> x31 reads 32'hA5A5_A5A5 and x30 is unchanged at 0.
- **Dual read / bypass:** with `BYPASS`=0, write 7 to x3 at edge N and read x3 in the same cycle -> old value 0, then 7 after the edge. With `BYPASS`=1, the same stimulus reads 7 in the same cycle. Read x3 on both ports -> both return 7.
- **Flags:** `flag_we`=1 with `{Z,N,C,V}`=1,0,1,0 -> `flags`=4'b1010 next cycle. `flag_we`=0 with different inputs -> `flags` stays 4'b1010.
- **Sticky overflow:**
  - `flag_we`=1, `ovf_in`=1 -> `sticky_ovf`=1.
  - Next capture with `ovf_in`=0 -> stays 1.
  - `sticky_clr`=1 alone -> 0.
  - `sticky_clr`=1 with `flag_we`=1 and `ovf_in`=1 in the same cycle -> 1.
- **Random regression:** 10,000 random reads and writes compared against a reference array, with x0 always reading 0.

Source files
------------

// File: rtl/singlecycleregfile.sv
// Architectural register file (x0 hardwired to zero) with the ALU {Z,N,C,V}
// flag register and a sticky overflow bit for software inspection.
module singlecycleregfile #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            flag_we,
    input  logic            zero_in,
    input  logic            neg_in,
    input  logic            carry_in,
    input  logic            ovf_in,
    output logic [3:0]      flags,
    output logic            sticky_ovf,
    input  logic            sticky_clr
);

    // Entry 0 is never written; it stays at its reset value and is masked on read.
    logic [XLEN-1:0] regs [0:31];
    logic            wr_en;

    assign wr_en = rd_we && (rd_addr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // Forwarding is gated by rst_n so reads show zero for the whole reset window.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (BYPASS && rst_n && wr_en && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (BYPASS && rst_n && wr_en && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags <= {zero_in, neg_in, carry_in, ovf_in};
        end
    end

    // A captured overflow wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (flag_we && ovf_in) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_singlecycleregfile.sv
// Directed and random bench for singlecycleregfile; a BYPASS=0 and a BYPASS=1
// instance share all inputs and are checked against a scoreboard queue.
module tb_singlecycleregfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, flag_we, zero_in, neg_in, carry_in, ovf_in, sticky_clr;
    logic [31:0] rd_data;
    logic [31:0] rs1_data, rs2_data, b_rs1_data, b_rs2_data;
    logic [3:0]  flags, b_flags;
    logic        sticky_ovf, b_sticky_ovf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_rf [0:31];
    logic [3:0]  ref_flags;
    logic        ref_sticky;

    singlecycleregfile #(.XLEN(32), .BYPASS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
        .carry_in(carry_in), .ovf_in(ovf_in),
        .flags(flags), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
    );

    singlecycleregfile #(.XLEN(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
        .carry_in(carry_in), .ovf_in(ovf_in),
        .flags(b_flags), .sticky_ovf(b_sticky_ovf), .sticky_clr(sticky_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %h expected queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        ref_flags  = 4'b0000;
        ref_sticky = 1'b0;
    endtask

    // Advance the reference by the currently driven inputs, then take one edge.
    task automatic step();
        if (rst_n) begin
            if (rd_we && rd_addr != 5'd0) ref_rf[rd_addr] = rd_data;
            if (flag_we) ref_flags = {zero_in, neg_in, carry_in, ovf_in};
            if (flag_we && ovf_in) ref_sticky = 1'b1;
            else if (sticky_clr) ref_sticky = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && rd_we && rd_addr == a) return rd_data;
        return ref_rf[a];
    endfunction

    initial begin
        rst_n = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd31; rd_addr = 5'd0; rd_data = 32'h0;
        rd_we = 1'b0; flag_we = 1'b0; zero_in = 1'b0; neg_in = 1'b0;
        carry_in = 1'b0; ovf_in = 1'b0; sticky_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset state
        push("reset_rs1", 32'h0);     check(rs1_data);
        push("reset_rs2", 32'h0);     check(rs2_data);
        push("reset_flags", 32'h0);   check({28'h0, flags});
        push("reset_sticky", 32'h0);  check({31'h0, sticky_ovf});
        rst_n = 1'b1;

        // preload x5 and set flags/sticky so the mid-cycle reset has something to clear
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hCAFE_BABE;
        flag_we = 1'b1; zero_in = 1'b1; ovf_in = 1'b1;
        step();
        rd_we = 1'b0; flag_we = 1'b0; zero_in = 1'b0; ovf_in = 1'b0;
        #1;
        push("preload_x5", 32'hCAFE_BABE); check(rs1_data);
        push("preload_flags", 32'h9);      check({28'h0, flags});
        push("preload_sticky", 32'h1);     check({31'h0, sticky_ovf});

        // asynchronous reset mid-cycle with a write pending
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h1234_5678;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        push("async_rst_rs1", 32'h0);    check(rs1_data);
        push("async_rst_flags", 32'h0);  check({28'h0, flags});
        push("async_rst_sticky", 32'h0); check({31'h0, sticky_ovf});
        step();
        push("rst_held_rs1", 32'h0);     check(rs1_data);
        rst_n = 1'b1;
        step();
        rd_we = 1'b0;
        #1;
        push("post_rst_write", 32'h1234_5678); check(rs1_data);

        // x0 write is discarded; bypass must not forward to x0 either
        rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        push("x0_byp_rs1", 32'h0); check(b_rs1_data);
        step();
        rd_we = 1'b0;
        #1;
        push("x0_rs1", 32'h0);     check(rs1_data);
        push("x0_rs2", 32'h0);     check(rs2_data);
        push("x0_b_rs2", 32'h0);   check(b_rs2_data);

        // x31 written, neighbour x30 untouched
        rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'hA5A5_A5A5;
        step();
        rd_we = 1'b0; rs1_addr = 5'd31; rs2_addr = 5'd30;
        #1;
        push("x31", 32'hA5A5_A5A5); check(rs1_data);
        push("x30", 32'h0);         check(rs2_data);

        // same-cycle read of a register being written
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'd7;
        #1;
        push("nobyp_old", 32'h0);   check(rs1_data);
        push("byp_rs1", 32'd7);     check(b_rs1_data);
        push("byp_rs2", 32'd7);     check(b_rs2_data);
        step();
        rd_we = 1'b0;
        #1;
        push("x3_rs1", 32'd7);      check(rs1_data);
        push("x3_rs2", 32'd7);      check(rs2_data);

        // flag capture then hold
        flag_we = 1'b1; zero_in = 1'b1; neg_in = 1'b0; carry_in = 1'b1; ovf_in = 1'b0;
        step();
        flag_we = 1'b0; zero_in = 1'b0; neg_in = 1'b1; carry_in = 1'b0; ovf_in = 1'b1;
        #1;
        push("flags_cap", 32'hA);   check({28'h0, flags});
        step();
        push("flags_hold", 32'hA);  check({28'h0, flags});
        push("sticky_no_we", 32'h0); check({31'h0, sticky_ovf});

        // sticky overflow sequence
        flag_we = 1'b1; ovf_in = 1'b1;
        step();
        push("sticky_set", 32'h1);  check({31'h0, sticky_ovf});
        ovf_in = 1'b0;
        step();
        push("sticky_keep", 32'h1); check({31'h0, sticky_ovf});
        flag_we = 1'b0; sticky_clr = 1'b1;
        step();
        push("sticky_clr", 32'h0);  check({31'h0, sticky_ovf});
        flag_we = 1'b1; ovf_in = 1'b1; sticky_clr = 1'b1;
        step();
        push("sticky_set_beats_clr", 32'h1); check({31'h0, sticky_ovf});
        flag_we = 1'b0; ovf_in = 1'b0; sticky_clr = 1'b0; neg_in = 1'b0;

        // random regression against the reference array
        for (int n = 0; n < 10000; n++) begin
            push("rnd_flags", {28'h0, ref_flags});     check({28'h0, flags});
            push("rnd_b_flags", {28'h0, ref_flags});   check({28'h0, b_flags});
            push("rnd_sticky", {31'h0, ref_sticky});   check({31'h0, sticky_ovf});
            push("rnd_b_sticky", {31'h0, ref_sticky}); check({31'h0, b_sticky_ovf});
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rd_we    = 1'($urandom_range(0, 1));
            flag_we  = ($urandom_range(0, 3) == 0);
            {zero_in, neg_in, carry_in, ovf_in} = 4'($urandom_range(0, 15));
            sticky_clr = ($urandom_range(0, 7) == 0);
            #1;
            push("rnd_rs1", ref_read(rs1_addr, 1'b0));   check(rs1_data);
            push("rnd_rs2", ref_read(rs2_addr, 1'b0));   check(rs2_data);
            push("rnd_b_rs1", ref_read(rs1_addr, 1'b1)); check(b_rs1_data);
            push("rnd_b_rs2", ref_read(rs2_addr, 1'b1)); check(b_rs2_data);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
